// File: rtl/except_merge_stage.sv
// Exception merge stage: picks the highest-priority new exception, merges it with the carried one,
// registers the result and holds a PENDING state until flush. Optional counter: EXCEPT_MERGE_CNT_EN.
module except_merge_stage #(
    parameter int XLEN    = 64,
    parameter int NSRC    = 4,
    parameter int CAUSE_W = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    valid_i,
    input  logic [XLEN-1:0]         pc_i,
    input  logic                    up_exc_i,
    input  logic [CAUSE_W-1:0]      up_cause_i,
    input  logic [XLEN-1:0]         up_tval_i,
    input  logic [NSRC-1:0]         src_req_i,
    input  logic [NSRC*CAUSE_W-1:0] src_cause_i,
    input  logic [NSRC*XLEN-1:0]    src_tval_i,
    output logic                    exc_o,
    output logic [CAUSE_W-1:0]      cause_o,
    output logic [XLEN-1:0]         epc_o,
    output logic [XLEN-1:0]         tval_o,
    output logic                    exc_new_o,
    output logic                    kill_o,
`ifdef EXCEPT_MERGE_CNT_EN
    output logic [31:0]             exc_cnt_o,
`endif
    output logic                    pending_o
);

    typedef enum logic {IDLE, PENDING} state_t;

    state_t               state_q, state_d;
    logic                 exc_q, exc_d;
    logic [CAUSE_W-1:0]   cause_q, cause_d;
    logic [XLEN-1:0]      epc_q, epc_d;
    logic [XLEN-1:0]      tval_q, tval_d;

    logic                 new_vld;
    logic [CAUSE_W-1:0]   new_cause;
    logic [XLEN-1:0]      new_tval;
    logic                 m_exc;
    logic [CAUSE_W-1:0]   m_cause;
    logic [XLEN-1:0]      m_tval;

    // Scan from the top so the lowest-index request is the last one written.
    always_comb begin
        new_cause = '0;
        new_tval  = '0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            if (src_req_i[k]) begin
                new_cause = src_cause_i[k*CAUSE_W +: CAUSE_W];
                new_tval  = src_tval_i[k*XLEN +: XLEN];
            end
        end
    end

    assign new_vld = valid_i & (|src_req_i);
    // The carried exception is already qualified upstream, so valid_i does not gate it.
    assign m_exc   = up_exc_i | new_vld;
    assign m_cause = up_exc_i ? up_cause_i : new_cause;
    assign m_tval  = up_exc_i ? up_tval_i  : new_tval;

    assign pending_o = (state_q == PENDING);
    assign exc_new_o = new_vld & ~up_exc_i & ~pending_o;
    assign kill_o    = pending_o & valid_i;

    always_comb begin
        state_d = state_q;
        exc_d   = exc_q;
        cause_d = cause_q;
        epc_d   = epc_q;
        tval_d  = tval_q;
        if (flush) begin
            state_d = IDLE;
            exc_d   = 1'b0;
            cause_d = '0;
            epc_d   = '0;
            tval_d  = '0;
        end else if (!stall) begin
            if (state_q == IDLE && m_exc) begin
                state_d = PENDING;
                exc_d   = 1'b1;
                cause_d = m_cause;
                epc_d   = pc_i;
                tval_d  = m_tval;
            end else begin
                // No exception, or a younger instruction behind a pending one.
                exc_d   = 1'b0;
                cause_d = '0;
                epc_d   = '0;
                tval_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            exc_q   <= 1'b0;
            cause_q <= '0;
            epc_q   <= '0;
            tval_q  <= '0;
        end else begin
            state_q <= state_d;
            exc_q   <= exc_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
            tval_q  <= tval_d;
        end
    end

    assign exc_o   = exc_q;
    assign cause_o = cause_q;
    assign epc_o   = epc_q;
    assign tval_o  = tval_q;

`ifdef EXCEPT_MERGE_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE && state_d == PENDING && cnt_q != 32'hFFFF_FFFF)
            cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign exc_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_except_merge_stage.sv
// Directed self-checking bench for except_merge_stage; counter checks build with EXCEPT_MERGE_CNT_EN.
module tb_except_merge_stage;

    localparam int XLEN = 64, NSRC = 4, CW = 6;

    logic clk = 1'b0, rst = 1'b0, stall = 1'b0, flush = 1'b0, valid_i = 1'b0;
    logic [XLEN-1:0] pc_i = '0, up_tval_i = '0;
    logic up_exc_i = 1'b0;
    logic [CW-1:0] up_cause_i = '0;
    logic [NSRC-1:0] src_req_i = '0;
    logic [NSRC*CW-1:0] src_cause_i;
    logic [NSRC*XLEN-1:0] src_tval_i;
    logic exc_o, exc_new_o, kill_o, pending_o;
    logic [CW-1:0] cause_o;
    logic [XLEN-1:0] epc_o, tval_o;
`ifdef EXCEPT_MERGE_CNT_EN
    logic [31:0] exc_cnt_o;
`endif

    int n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    except_merge_stage #(.XLEN(XLEN), .NSRC(NSRC), .CAUSE_W(CW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_i(valid_i), .pc_i(pc_i),
        .up_exc_i(up_exc_i), .up_cause_i(up_cause_i), .up_tval_i(up_tval_i),
        .src_req_i(src_req_i), .src_cause_i(src_cause_i), .src_tval_i(src_tval_i),
        .exc_o(exc_o), .cause_o(cause_o), .epc_o(epc_o), .tval_o(tval_o),
        .exc_new_o(exc_new_o), .kill_o(kill_o),
`ifdef EXCEPT_MERGE_CNT_EN
        .exc_cnt_o(exc_cnt_o),
`endif
        .pending_o(pending_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1; valid_i = 1'b0; src_req_i = '0; up_exc_i = 1'b0;
        step();
        flush = 1'b0;
    endtask

    initial begin
        // source k: cause {2,3,5,7}[k], tval 0xA0+k
        src_cause_i = {6'd7, 6'd5, 6'd3, 6'd2};
        src_tval_i  = {64'hA3, 64'hA2, 64'hA1, 64'hA0};

        step(); step();
        chk("rst_exc", exc_o, 0);
        chk("rst_cause", cause_o, 0);
        chk("rst_epc", epc_o, 0);
        chk("rst_pend", pending_o, 0);
        @(negedge clk); rst = 1'b1;
        #2;

        // lowest-index request wins
        valid_i = 1'b1; pc_i = 64'h1000; src_req_i = 4'b0110;
        #1 chk("sel_exc_new", exc_new_o, 1);
        chk("sel_kill", kill_o, 0);
        step();
        chk("sel_exc", exc_o, 1);
        chk("sel_cause", cause_o, 3);
        chk("sel_epc", epc_o, 64'h1000);
        chk("sel_tval", tval_o, 64'hA1);
        chk("sel_pend", pending_o, 1);
        do_flush();
        chk("fl_exc", exc_o, 0);
        chk("fl_pend", pending_o, 0);

        // carried exception beats new sources
        valid_i = 1'b1; pc_i = 64'h1100; up_exc_i = 1'b1; up_cause_i = 6'd12;
        up_tval_i = 64'hBEEF; src_req_i = 4'b0001;
        #1 chk("up_exc_new", exc_new_o, 0);
        step();
        chk("up_cause", cause_o, 12);
        chk("up_tval", tval_o, 64'hBEEF);
        chk("up_epc", epc_o, 64'h1100);
        do_flush();

        // carried exception is not gated by valid_i
        valid_i = 1'b0; up_exc_i = 1'b1; up_cause_i = 6'd9; pc_i = 64'h1180;
        step();
        chk("upnv_exc", exc_o, 1);
        chk("upnv_cause", cause_o, 9);
        do_flush();

        // younger instructions killed while pending
        valid_i = 1'b1; pc_i = 64'h1200; src_req_i = 4'b1000;
        step();
        chk("pk_cause", cause_o, 7);
        chk("pk_tval", tval_o, 64'hA3);
        src_req_i = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            pc_i = 64'h1204 + 64'(4 * i);
            #1 chk("pk_kill", kill_o, 1);
            chk("pk_exc_new", exc_new_o, 0);
            step();
            chk("pk_exc0", exc_o, 0);
            chk("pk_pend", pending_o, 1);
        end
        do_flush();
        chk("pk_idle", pending_o, 0);
        chk("pk_nokill", kill_o, 0);

        // stall holds, then flush beats stall
        valid_i = 1'b1; pc_i = 64'h2000; src_req_i = 4'b0001;
        step();
        stall = 1'b1; pc_i = 64'h3000; src_req_i = '0;
        step(); step();
        chk("st_exc", exc_o, 1);
        chk("st_epc", epc_o, 64'h2000);
        chk("st_cause", cause_o, 2);
        chk("st_pend", pending_o, 1);
        flush = 1'b1;
        step();
        chk("sf_exc", exc_o, 0);
        chk("sf_pend", pending_o, 0);
        stall = 1'b0; flush = 1'b0;

        // flush coinciding with a new exception
        flush = 1'b1; valid_i = 1'b1; src_req_i = 4'b0001;
        step();
        chk("fx_exc", exc_o, 0);
        chk("fx_pend", pending_o, 0);
        flush = 1'b0;

        // plain capture with no exception zeroes everything
        valid_i = 1'b1; src_req_i = '0; pc_i = 64'h4000;
        step();
        chk("ne_exc", exc_o, 0);
        chk("ne_epc", epc_o, 0);
        chk("ne_pend", pending_o, 0);

        // asynchronous reset while pending
        src_req_i = 4'b0010; pc_i = 64'h5000;
        step();
        chk("ar_pre", exc_o, 1);
        src_req_i = '0; valid_i = 1'b0;
        #1 rst = 1'b0;
        #1 chk("ar_exc", exc_o, 0);
        chk("ar_cause", cause_o, 0);
        chk("ar_epc", epc_o, 0);
        chk("ar_tval", tval_o, 0);
        chk("ar_pend", pending_o, 0);
        @(negedge clk); rst = 1'b1;
        valid_i = 1'b1; src_req_i = 4'b0100; pc_i = 64'h6000;
        step();
        chk("rs_exc", exc_o, 1);
        chk("rs_cause", cause_o, 5);
        do_flush();

`ifdef EXCEPT_MERGE_CNT_EN
        chk("cnt_one", exc_cnt_o, 1);
        for (int i = 0; i < 4; i++) begin
            valid_i = 1'b1; src_req_i = 4'b0001;
            step();
            do_flush();
        end
        chk("cnt_five", exc_cnt_o, 5);
        @(negedge clk); force dut.cnt_q = 32'hFFFF_FFFF;
        @(negedge clk); release dut.cnt_q;
        chk("cnt_force", exc_cnt_o, 32'hFFFF_FFFF);
        valid_i = 1'b1; src_req_i = 4'b0001;
        step();
        chk("cnt_sat", exc_cnt_o, 32'hFFFF_FFFF);
        do_flush();
        chk("cnt_flush", exc_cnt_o, 32'hFFFF_FFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/except_merge_stage.md
EXCEPT_MERGE_STAGE -- requirements
Module: except_merge_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, data/PC width.
REQ-002 SHALL have parameter NSRC, default 4, number of new exception sources checked in this stage (1..8).
REQ-003 SHALL have parameter CAUSE_W, default 6, cause code width.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- stall  in  1  hold output register
- flush  in  1  clear output register and pending state
- valid_i  in  1  instruction in stage is valid
- pc_i  in  XLEN  stage PC
- up_exc_i  in  1  exception carried from earlier stage
- up_cause_i  in  CAUSE_W  carried cause
- up_tval_i  in  XLEN  carried tval
- src_req_i  in  NSRC  new exception requests, bit 0 highest priority
- src_cause_i  in  NSRC*CAUSE_W  per-source cause, source k at bits [k*CAUSE_W +: CAUSE_W]
- src_tval_i  in  NSRC*XLEN  per-source tval, same packing
- exc_o  out  1  registered exception valid
- cause_o  out  CAUSE_W  registered cause
- epc_o  out  XLEN  registered faulting PC
- tval_o  out  XLEN  registered tval
- exc_new_o  out  1  combinational: this stage raises the first exception of the instruction
- kill_o  out  1  combinational: younger instruction in stage is suppressed
- pending_o  out  1  exception in flight, awaiting flush

Function
REQ-005 SHALL select the new exception as the lowest-index asserted src_req_i bit, gated by valid_i.
REQ-006 SHALL give up_exc_i priority over any new source; merged = up_exc_i ? carried : selected new.
REQ-007 SHALL drive exc_new_o = valid_i & |src_req_i & ~up_exc_i & ~pending_o.
REQ-008 SHALL treat every up_exc_i as already gated upstream and not re-gate it with valid_i.
REQ-009 SHALL capture merged exc/cause/pc/tval into output registers on each clk rising edge when stall=0 and flush=0; epc_o takes pc_i.
REQ-010 SHALL, on capture with no exception, load exc_o=0 and cause_o/epc_o/tval_o=0.
REQ-011 SHALL hold all output registers while stall=1 and flush=0.
REQ-012 SHALL, on flush=1, clear output registers to 0 on the next edge regardless of stall; flush dominates stall.
REQ-013 SHALL implement two states: IDLE, PENDING; pending_o=1 in PENDING.
REQ-014 SHALL move IDLE->PENDING on a capture edge where the merged exception is valid.
REQ-015 SHALL move PENDING->IDLE only on flush=1; PENDING holds through stall.
REQ-016 SHALL, in PENDING, drive kill_o = valid_i and capture no exception (exc_o loaded 0) from younger instructions.
REQ-017 SHALL, when flush and a new exception coincide, take the flush: state IDLE, registers cleared.

Reset
REQ-018 SHALL on rst=0 asynchronously force state IDLE and exc_o, cause_o, epc_o, tval_o to 0, including mid-stall or mid-PENDING.
REQ-019 SHALL resume normal capture on the first edge after rst deasserts.

Configuration
REQ-020 SHALL, with macro EXCEPT_MERGE_CNT_EN defined, add output exc_cnt_o (32 bits) counting IDLE->PENDING transitions, saturating at 0xFFFFFFFF, reset to 0, unaffected by flush.
REQ-021 SHALL, without EXCEPT_MERGE_CNT_EN, omit exc_cnt_o and its counter; all other behaviour identical.

Verification
REQ-022 SHALL cover: valid_i=1, src_req_i=4'b0110, causes 2/3/5/7 -> next edge exc_o=1, cause_o=3, epc_o=pc_i, exc_new_o=1 before edge.
REQ-023 SHALL cover: up_exc_i=1 cause 12 with src_req_i=4'b0001 -> cause_o=12, exc_new_o=0.
REQ-024 SHALL cover: exception captured, then 3 valid younger instructions with src_req_i=1 -> kill_o=1 each, exc_o=0 after first, pending_o=1 until flush, then IDLE.
REQ-025 SHALL cover: stall=1 and flush=1 same cycle with exc_o=1 -> exc_o=0 next edge, pending_o=0.
REQ-026 SHALL cover: rst=0 between edges while PENDING, exc_o=1 -> outputs 0 immediately, no clock needed.
REQ-027 SHALL cover, with EXCEPT_MERGE_CNT_EN: 5 exception/flush pairs -> exc_cnt_o=5; preload counter to 0xFFFFFFFF via force -> stays saturated.
